// File: rtl/motor_pwm_ctrl_pkg.sv
// Shared types and constants for the motor PWM controller and its channels.
// Mode encodings match the SPI register block and the driver-side code.
// FSM state codes extend the mode codes by one bit so a request maps directly onto a state.
package motor_pwm_ctrl_pkg;

  localparam int NUM_CH = 4;
  localparam int DUTY_W = 16;
  localparam int DEAD_W = 8;

  // Requested drive mode per channel (2 bits in mot_drive_code)
  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_FWD   = 2'b01,
    MODE_REV   = 2'b10,
    MODE_BRAKE = 2'b11
  } mode_t;

  // Channel FSM states; OFF/FWD/REV/BRAKE share their mode code, DEAD is the extra one
  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_FWD   = 3'd1;
  localparam logic [2:0] ST_REV   = 3'd2;
  localparam logic [2:0] ST_BRAKE = 3'd3;
  localparam logic [2:0] ST_DEAD  = 3'd4;

  // Steady state that a given request settles into
  function automatic logic [2:0] mode_to_state(input mode_t m);
    return {1'b0, m};
  endfunction

endpackage

// File: rtl/motor_pwm_ctrl_if.sv
// Command/pin bundle between the SPI register block, the PWM controller and the bridge pins.
// master = register side (drives commands, observes pins); slave = the controller.
// No handshake: commands are level registers, sampled every cycle.
interface motor_pwm_ctrl_if;
  import motor_pwm_ctrl_pkg::*;

  logic [DUTY_W-1:0]   mot_duty0;
  logic [DUTY_W-1:0]   mot_duty1;
  logic [DUTY_W-1:0]   mot_duty2;
  logic [DUTY_W-1:0]   mot_duty3;
  logic [2*NUM_CH-1:0] mot_drive_code;
  logic [NUM_CH:0]     mot_allstop;
  logic [NUM_CH-1:0]   mot_a;
  logic [NUM_CH-1:0]   mot_b;
  logic                pwm_sync;

  modport master (
    output mot_duty0, mot_duty1, mot_duty2, mot_duty3,
    output mot_drive_code, mot_allstop,
    input  mot_a, mot_b, pwm_sync
  );

  modport slave (
    input  mot_duty0, mot_duty1, mot_duty2, mot_duty3,
    input  mot_drive_code, mot_allstop,
    output mot_a, mot_b, pwm_sync
  );

endinterface

// File: rtl/motor_pwm_ctrl_channel.sv
// One H-bridge channel: duty shadow, mode FSM with dead-time, registered a/b pins.
// Latency: request -> state 1 cycle, state/pwm -> pins 1 cycle (2 cycles request -> pins).
// No backpressure: request and duty are sampled every cycle; duty only at period wrap.
module motor_pwm_ctrl_channel
  import motor_pwm_ctrl_pkg::*;
#(
  parameter logic [DEAD_W-1:0] DEADTIME = 8'd16
) (
  input  logic              SYS_CLK,
  input  logic              RESET,
  input  logic [DUTY_W-1:0] i_cnt,
  input  logic              i_wrap,
  input  logic [DUTY_W-1:0] i_duty,
  input  mode_t             i_req,
  output logic              o_a,
  output logic              o_b
);

  logic [DUTY_W-1:0] r_shadow;
  logic [2:0]        r_state;
  logic [DEAD_W-1:0] r_dcnt;
  logic              r_a;
  logic              r_b;

  logic [2:0]        w_state_nxt;
  logic [DEAD_W-1:0] w_dcnt_nxt;
  logic [2:0]        w_req_state;
  logic              w_pwm;

  assign w_req_state = mode_to_state(i_req);

  // Shadow at/over PERIOD keeps the comparison true for the whole period (100%)
  assign w_pwm = (i_cnt < r_shadow);

  // Duty is captured only on the last count so a running period is never disturbed
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      r_shadow <= '0;
    end else if (i_wrap) begin
      r_shadow <= i_duty;
    end
  end

  // Mode transitions: OFF is always immediate, conflicting drive modes go through DEAD
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    if (i_req == MODE_OFF) begin
      w_state_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = w_req_state;
        end
        ST_DEAD: begin
          // Exit into whatever is requested now; a mid-dead change does not restart the count
          if (r_dcnt == '0) begin
            w_state_nxt = w_req_state;
          end else begin
            w_dcnt_nxt = r_dcnt - 1'b1;
          end
        end
        ST_FWD, ST_REV, ST_BRAKE: begin
          if (w_req_state != r_state) begin
            w_state_nxt = ST_DEAD;
            w_dcnt_nxt  = DEADTIME - 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
        end
      endcase
    end
  end

  // State and dead counter registers
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_OFF;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  // Registered pin drive; only BRAKE ever sets both inputs together
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      r_a <= 1'b0;
      r_b <= 1'b0;
    end else begin
      case (r_state)
        ST_FWD: begin
          r_a <= w_pwm;
          r_b <= 1'b0;
        end
        ST_REV: begin
          r_a <= 1'b0;
          r_b <= w_pwm;
        end
        ST_BRAKE: begin
          r_a <= 1'b1;
          r_b <= 1'b1;
        end
        default: begin
          r_a <= 1'b0;
          r_b <= 1'b0;
        end
      endcase
    end
  end

  assign o_a = r_a;
  assign o_b = r_b;

endmodule

// File: rtl/motor_pwm_ctrl.sv
// Four-channel motor PWM: shared timebase, pwm_sync pulse, allstop override, channel array.
// Latency: drive_code/allstop -> pins 2 cycles; duty takes effect at the next period start.
// No backpressure: command registers are level inputs sampled every cycle.
module motor_pwm_ctrl
  import motor_pwm_ctrl_pkg::*;
#(
  parameter logic [DUTY_W-1:0] PERIOD   = 16'd2600,
  parameter logic [DEAD_W-1:0] DEADTIME = 8'd16
) (
  input  logic               SYS_CLK,
  input  logic               RESET,
  motor_pwm_ctrl_if.slave    bus
);

  logic [DUTY_W-1:0] r_cnt;
  logic              r_pwm_sync;

  logic              w_wrap;
  logic [DUTY_W-1:0] w_duty  [NUM_CH];
  mode_t             w_req   [NUM_CH];
  logic [NUM_CH-1:0] w_force;
  logic [NUM_CH-1:0] w_a;
  logic [NUM_CH-1:0] w_b;

  assign w_wrap = (r_cnt == PERIOD - 16'd1);

  // Free-running timebase 0..PERIOD-1
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Sync pulse lines up with the cycle in which the counter reads 0
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      r_pwm_sync <= 1'b0;
    end else begin
      r_pwm_sync <= w_wrap;
    end
  end

  assign w_duty[0] = bus.mot_duty0;
  assign w_duty[1] = bus.mot_duty1;
  assign w_duty[2] = bus.mot_duty2;
  assign w_duty[3] = bus.mot_duty3;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Global or per-channel allstop overrides the SPI drive code with BRAKE
    assign w_force[g] = bus.mot_allstop[NUM_CH] | bus.mot_allstop[g];
    assign w_req[g]   = w_force[g] ? MODE_BRAKE : mode_t'(bus.mot_drive_code[2*g +: 2]);

    motor_pwm_ctrl_channel #(
      .DEADTIME (DEADTIME)
    ) u_ch (
      .SYS_CLK (SYS_CLK),
      .RESET   (RESET),
      .i_cnt   (r_cnt),
      .i_wrap  (w_wrap),
      .i_duty  (w_duty[g]),
      .i_req   (w_req[g]),
      .o_a     (w_a[g]),
      .o_b     (w_b[g])
    );
  end

  assign bus.mot_a    = w_a;
  assign bus.mot_b    = w_b;
  assign bus.pwm_sync = r_pwm_sync;

endmodule
